// File: rtl/frame_sequencer.sv
// frame_sequencer: loads one pixel frame from UART into BRAM, runs the centroid engine, sends the 32-bit result back over UART.
// Optional feature macro RX_TIMEOUT_EN: aborts a stalled load after TIMEOUT_CYC idle cycles and pulses err_timeout.
module frame_sequencer #(
  parameter int FRAME_BYTES = 2500,
  parameter int ADDR_W      = 16,
  parameter int TIMEOUT_CYC = 2_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [7:0]        bram_din,
  output logic              bram_sel,
  output logic              cen_start,
  input  logic              cen_done,
  input  logic [15:0]       cen_x,
  input  logic [15:0]       cen_y,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_busy,
  output logic              frame_done,
  output logic              overrun,
  output logic              err_timeout
);
  typedef enum logic [2:0] {IDLE, LOAD, START, COMPUTE, SEND, TXWAIT} state_t;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_BYTES - 1);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] count_q, count_d, addr_q, addr_d;
  logic [7:0] din_q, din_d, tx_data_q, tx_data_d, tx_byte;
  logic [31:0] res_q, res_d;
  logic [1:0] idx_q, idx_d;
  logic we_q, we_d, sel_q, sel_d, cs_q, cs_d, txs_q, txs_d, fd_q, fd_d, ov_q, ov_d, skip_q, skip_d;
  assign tx_byte = res_q[{~idx_q, 3'b000} +: 8];
`ifdef RX_TIMEOUT_EN
  logic [31:0] tmo_q, tmo_d;
  logic to_q, to_d;
  assign tmo_d = (state_q != LOAD || rx_valid) ? '0 : tmo_q + 32'd1;
  assign to_d = state_q == LOAD && !rx_valid && tmo_d == 32'(TIMEOUT_CYC - 1);
  // idle-line counter and abort strobe, only counting while a load is in progress
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      tmo_q <= '0;
      to_q  <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      to_q  <= to_d;
    end
  assign err_timeout = to_q;
`else
  localparam int unused_timeout = TIMEOUT_CYC;
  assign err_timeout = 1'b0;
`endif
  // next-state and registered-output logic for the load/compute/send sequence
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    addr_d    = addr_q;
    din_d     = din_q;
    we_d      = 1'b0;
    sel_d     = sel_q;
    cs_d      = 1'b0;
    txs_d     = 1'b0;
    tx_data_d = tx_data_q;
    res_d     = res_q;
    idx_d     = idx_q;
    fd_d      = 1'b0;
    skip_d    = 1'b0;
    ov_d      = rx_valid && !(state_q == IDLE || state_q == LOAD);
    case (state_q)
      IDLE: begin
        sel_d   = 1'b0;
        count_d = '0;
        if (rx_valid) begin
          we_d    = 1'b1;
          addr_d  = '0;
          din_d   = rx_data;
          count_d = ADDR_W'(1);
          state_d = LOAD;
        end
      end
      LOAD:
        if (rx_valid) begin
          we_d    = 1'b1;
          addr_d  = count_q;
          din_d   = rx_data;
          count_d = count_q == LAST ? count_q : count_q + 1'b1;
          state_d = count_q == LAST ? START : LOAD;
        end
`ifdef RX_TIMEOUT_EN
        else if (to_d) begin
          count_d = '0;
          state_d = IDLE;
        end
`endif
      START: begin
        sel_d   = 1'b1;
        cs_d    = 1'b1;
        state_d = COMPUTE;
      end
      COMPUTE:
        if (cen_done) begin
          res_d   = {cen_x, cen_y};
          idx_d   = '0;
          state_d = SEND;
        end
      SEND:
        if (!tx_busy) begin
          txs_d     = 1'b1;
          tx_data_d = tx_byte;
          skip_d    = 1'b1;
          state_d   = TXWAIT;
        end
      TXWAIT:
        if (!skip_q && !tx_busy) begin
          idx_d   = idx_q + 2'd1;
          fd_d    = idx_q == 2'd3;
          sel_d   = idx_q == 2'd3 ? 1'b0 : sel_q;
          count_d = idx_q == 2'd3 ? '0 : count_q;
          state_d = idx_q == 2'd3 ? IDLE : SEND;
        end
      default: state_d = IDLE;
    endcase
  end
  // state and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      addr_q    <= '0;
      din_q     <= '0;
      we_q      <= 1'b0;
      sel_q     <= 1'b0;
      cs_q      <= 1'b0;
      txs_q     <= 1'b0;
      tx_data_q <= '0;
      res_q     <= '0;
      idx_q     <= '0;
      fd_q      <= 1'b0;
      ov_q      <= 1'b0;
      skip_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      cs_q      <= cs_d;
      txs_q     <= txs_d;
      tx_data_q <= tx_data_d;
      res_q     <= res_d;
      idx_q     <= idx_d;
      fd_q      <= fd_d;
      ov_q      <= ov_d;
      skip_q    <= skip_d;
    end
  assign bram_we    = we_q;
  assign bram_addr  = addr_q;
  assign bram_din   = din_q;
  assign bram_sel   = sel_q;
  assign cen_start  = cs_q;
  assign tx_start   = txs_q;
  assign tx_data    = tx_data_q;
  assign frame_done = fd_q;
  assign overrun    = ov_q;
endmodule
